// File: rtl/l2tlb_resp_pkg.sv
// L1-TLB/L2-TLB protocol payload types and fault encodings shared by the
// l2tlb_resp block and its bench.
package l2tlb_resp_pkg;

    localparam int TXID_W   = 5;
    localparam int LADDR_W  = 39;
    localparam int HPADDR_W = 11;
    localparam int PPADDR_W = 3;
    localparam int FAULT_W  = 3;

    localparam logic [FAULT_W-1:0] FAULT_NONE  = 3'b000;
    localparam logic [FAULT_W-1:0] FAULT_RANGE = 3'b001;

    typedef struct packed {
        logic [TXID_W-1:0]  txid;
        logic [LADDR_W-1:0] laddr;
    } I_l1tlbtol2tlb_req_type;

    typedef struct packed {
        logic [TXID_W-1:0]   txid;
        logic [HPADDR_W-1:0] hpaddr;
        logic [PPADDR_W-1:0] ppaddr;
        logic [FAULT_W-1:0]  fault;
    } I_l2tlbtol1tlb_ack_type;

    typedef struct packed {
        logic [TXID_W-1:0]   txid;
        logic [HPADDR_W-1:0] hpaddr;
    } I_l2tlbtol1tlb_snoop_type;

    typedef struct packed {
        logic [TXID_W-1:0] txid;
    } I_l1tlbtol2tlb_sack_type;

endpackage

// File: rtl/fflop.sv
// One-entry registered valid/retry stage: output valid and payload come
// straight from flops; a new entry is accepted whenever the slot is free or draining.
module fflop #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         din_valid,
    output logic         din_retry,
    input  logic [W-1:0] din,
    output logic         dout_valid,
    input  logic         dout_retry,
    output logic [W-1:0] dout
);

    assign din_retry = dout_valid & dout_retry;

    always_ff @(posedge clk) begin
        if (din_valid && !din_retry) begin
            dout <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid <= 1'b0;
        end else if (din_valid && !din_retry) begin
            dout_valid <= 1'b1;
        end else if (!dout_retry) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/l2tlb_req_fifo.sv
// Request FIFO with valid/retry on both sides. Full is taken from the
// registered count, so a pop only frees a slot for pushes from the next cycle.
module l2tlb_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_retry,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_retry,
    output logic [W-1:0] out_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign in_retry  = reset | (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & ~in_retry;
    assign pop       = out_valid & ~out_retry;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits and wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/l2tlb_resp.sv
// l2tlb_resp: bring-up L2 TLB responder (fixed-latency identity walk, snoop injection).
// Optional feature macro L2TLB_FAULT_CHECK_EN: laddr bits above 22 return a FAULT_RANGE ack.
module l2tlb_resp
    import l2tlb_resp_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int WALK_LAT  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     l1tlbtol2tlb_req_valid,
    output logic                     l1tlbtol2tlb_req_retry,
    input  I_l1tlbtol2tlb_req_type   l1tlbtol2tlb_req,
    output logic                     l2tlbtol1tlb_ack_valid,
    input  logic                     l2tlbtol1tlb_ack_retry,
    output I_l2tlbtol1tlb_ack_type   l2tlbtol1tlb_ack,
    input  logic                     inv_valid,
    output logic                     inv_retry,
    input  I_l2tlbtol1tlb_snoop_type inv,
    output logic                     l2tlbtol1tlb_snoop_valid,
    input  logic                     l2tlbtol1tlb_snoop_retry,
    output I_l2tlbtol1tlb_snoop_type l2tlbtol1tlb_snoop,
    input  logic                     l1tlbtol2tlb_sack_valid,
    output logic                     l1tlbtol2tlb_sack_retry,
    input  I_l1tlbtol2tlb_sack_type  l1tlbtol2tlb_sack
);

    localparam int CNT_W   = $clog2(WALK_LAT) + 1;
    localparam int ACK_W   = $bits(I_l2tlbtol1tlb_ack_type);
    localparam int SNOOP_W = $bits(I_l2tlbtol1tlb_snoop_type);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK,
        ST_ACK,
        ST_SNOOP,
        ST_WAIT_SACK
    } state_t;

    typedef struct packed {
        logic [TXID_W-1:0]  txid;
        logic [LADDR_W-1:0] laddr;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   err_sack;
    req_entry_t             cur;
    logic [TXID_W-1:0]      snp_txid;

    req_entry_t             fifo_in;
    logic [ENTRY_W-1:0]     fifo_out_data;
    logic                   fifo_out_valid;
    logic                   fifo_out_retry;
    logic                   fifo_pop;

    I_l2tlbtol1tlb_ack_type ack_din;
    logic                   ack_din_retry;
    logic [ACK_W-1:0]       ack_dout;
    logic                   snoop_din_retry;
    logic [SNOOP_W-1:0]     snoop_dout;

    logic                   walk_done;
    logic                   ack_go;
    logic                   ack_done;
    logic                   snoop_done;
    logic                   inv_take;
    logic                   sack_match;
    logic                   unused_laddr;

    function automatic I_l2tlbtol1tlb_ack_type build_ack(input req_entry_t e);
        I_l2tlbtol1tlb_ack_type a;
        a.txid   = e.txid;
        a.hpaddr = e.laddr[22:12];
        a.ppaddr = e.laddr[14:12];
        a.fault  = FAULT_NONE;
`ifdef L2TLB_FAULT_CHECK_EN
        if (|e.laddr[LADDR_W-1:23]) begin
            a.hpaddr = '0;
            a.ppaddr = '0;
            a.fault  = FAULT_RANGE;
        end
`endif
        return a;
    endfunction

    assign fifo_in = '{txid: l1tlbtol2tlb_req.txid, laddr: l1tlbtol2tlb_req.laddr};

    l2tlb_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .W     (ENTRY_W)
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (l1tlbtol2tlb_req_valid),
        .in_retry  (l1tlbtol2tlb_req_retry),
        .in_data   (fifo_in),
        .out_valid (fifo_out_valid),
        .out_retry (fifo_out_retry),
        .out_data  (fifo_out_data)
    );

    // Invalidation wins over queued requests when both are pending in IDLE.
    assign inv_retry      = reset | (state != ST_IDLE) | snoop_din_retry;
    assign inv_take       = inv_valid & ~inv_retry;
    assign fifo_pop       = ~reset & (state == ST_IDLE) & ~inv_valid & fifo_out_valid;
    assign fifo_out_retry = ~fifo_pop;

    // The ack enters its output flop on the last walk cycle so it is visible
    // the same cycle the FSM reaches ACK.
    assign walk_done = (state == ST_WALK) && (cnt == '0);
    assign ack_din   = build_ack(cur);
    assign ack_go    = walk_done & ~ack_din_retry;

    fflop #(.W(ACK_W)) u_ack_flop (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (walk_done),
        .din_retry  (ack_din_retry),
        .din        (ack_din),
        .dout_valid (l2tlbtol1tlb_ack_valid),
        .dout_retry (l2tlbtol1tlb_ack_retry),
        .dout       (ack_dout)
    );

    fflop #(.W(SNOOP_W)) u_snoop_flop (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (inv_take),
        .din_retry  (snoop_din_retry),
        .din        (inv),
        .dout_valid (l2tlbtol1tlb_snoop_valid),
        .dout_retry (l2tlbtol1tlb_snoop_retry),
        .dout       (snoop_dout)
    );

    assign l2tlbtol1tlb_ack   = I_l2tlbtol1tlb_ack_type'(ack_dout);
    assign l2tlbtol1tlb_snoop = I_l2tlbtol1tlb_snoop_type'(snoop_dout);

    assign ack_done   = l2tlbtol1tlb_ack_valid & ~l2tlbtol1tlb_ack_retry;
    assign snoop_done = l2tlbtol1tlb_snoop_valid & ~l2tlbtol1tlb_snoop_retry;

    // Snoop acks are always consumed; only a matching one in WAIT_SACK counts.
    assign l1tlbtol2tlb_sack_retry = 1'b0;
    assign sack_match = (state == ST_WAIT_SACK) && (l1tlbtol2tlb_sack.txid == snp_txid);

    assign unused_laddr = ^cur.laddr;

    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            cur <= req_entry_t'(fifo_out_data);
        end
        if (inv_take) begin
            snp_txid <= inv.txid;
        end
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            err_sack <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inv_take) begin
                        state <= ST_SNOOP;
                    end else if (fifo_pop) begin
                        cnt   <= CNT_W'(WALK_LAT - 1);
                        state <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (ack_go) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (ack_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SNOOP: begin
                    if (snoop_done) begin
                        state <= ST_WAIT_SACK;
                    end
                end
                ST_WAIT_SACK: begin
                    if (l1tlbtol2tlb_sack_valid && sack_match) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (l1tlbtol2tlb_sack_valid && !sack_match) begin
                err_sack <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l2tlb_resp.sv
// Bench for l2tlb_resp: directed scenarios plus randomized traffic against a
// queue-based reference model of the ack rules.
module tb_l2tlb_resp;
    import l2tlb_resp_pkg::*;

    localparam int REQ_DEPTH = 4;
    localparam int WALK_LAT  = 8;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     l1tlbtol2tlb_req_valid = 1'b0;
    logic                     l1tlbtol2tlb_req_retry;
    I_l1tlbtol2tlb_req_type   l1tlbtol2tlb_req = '0;
    logic                     l2tlbtol1tlb_ack_valid;
    logic                     l2tlbtol1tlb_ack_retry = 1'b0;
    I_l2tlbtol1tlb_ack_type   l2tlbtol1tlb_ack;
    logic                     inv_valid = 1'b0;
    logic                     inv_retry;
    I_l2tlbtol1tlb_snoop_type inv = '0;
    logic                     l2tlbtol1tlb_snoop_valid;
    logic                     l2tlbtol1tlb_snoop_retry = 1'b0;
    I_l2tlbtol1tlb_snoop_type l2tlbtol1tlb_snoop;
    logic                     l1tlbtol2tlb_sack_valid = 1'b0;
    logic                     l1tlbtol2tlb_sack_retry;
    I_l1tlbtol2tlb_sack_type  l1tlbtol2tlb_sack = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    I_l2tlbtol1tlb_ack_type   got_q[$];
    int                       got_cyc[$];
    I_l2tlbtol1tlb_ack_type   exp_q[$];
    I_l2tlbtol1tlb_snoop_type snp_q[$];
    int                       snp_cyc[$];

    l2tlb_resp #(
        .REQ_DEPTH (REQ_DEPTH),
        .WALK_LAT  (WALK_LAT)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .l1tlbtol2tlb_req_valid   (l1tlbtol2tlb_req_valid),
        .l1tlbtol2tlb_req_retry   (l1tlbtol2tlb_req_retry),
        .l1tlbtol2tlb_req         (l1tlbtol2tlb_req),
        .l2tlbtol1tlb_ack_valid   (l2tlbtol1tlb_ack_valid),
        .l2tlbtol1tlb_ack_retry   (l2tlbtol1tlb_ack_retry),
        .l2tlbtol1tlb_ack         (l2tlbtol1tlb_ack),
        .inv_valid                (inv_valid),
        .inv_retry                (inv_retry),
        .inv                      (inv),
        .l2tlbtol1tlb_snoop_valid (l2tlbtol1tlb_snoop_valid),
        .l2tlbtol1tlb_snoop_retry (l2tlbtol1tlb_snoop_retry),
        .l2tlbtol1tlb_snoop       (l2tlbtol1tlb_snoop),
        .l1tlbtol2tlb_sack_valid  (l1tlbtol2tlb_sack_valid),
        .l1tlbtol2tlb_sack_retry  (l1tlbtol2tlb_sack_retry),
        .l1tlbtol2tlb_sack        (l1tlbtol2tlb_sack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed transfer on the two output ports.
    always @(negedge clk) begin
        if (l2tlbtol1tlb_ack_valid === 1'b1 && l2tlbtol1tlb_ack_retry === 1'b0) begin
            got_q.push_back(l2tlbtol1tlb_ack);
            got_cyc.push_back(cyc);
        end
        if (l2tlbtol1tlb_snoop_valid === 1'b1 && l2tlbtol1tlb_snoop_retry === 1'b0) begin
            snp_q.push_back(l2tlbtol1tlb_snoop);
            snp_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: identity walk computed with plain arithmetic on the address.
    function automatic I_l2tlbtol1tlb_ack_type model_ack(input logic [TXID_W-1:0] t,
                                                         input logic [LADDR_W-1:0] a);
        I_l2tlbtol1tlb_ack_type m;
        longint unsigned la;
        la       = 64'(a);
        m.txid   = t;
        m.hpaddr = HPADDR_W'((la / 4096) % 2048);
        m.ppaddr = PPADDR_W'((la / 4096) % 8);
        m.fault  = 3'd0;
`ifdef L2TLB_FAULT_CHECK_EN
        if (la >= 64'd8388608) begin
            m.hpaddr = '0;
            m.ppaddr = '0;
            m.fault  = 3'd1;
        end
`endif
        return m;
    endfunction

    function automatic logic [LADDR_W-1:0] rand_laddr();
        longint unsigned r;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) r = r % 64'd8388608;
        return LADDR_W'(r);
    endfunction

    task automatic clear_queues();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        snp_q.delete();
        snp_cyc.delete();
    endtask

    task automatic send_req(input logic [TXID_W-1:0] t, input logic [LADDR_W-1:0] a,
                            output int acc_cyc);
        l1tlbtol2tlb_req_valid = 1'b1;
        l1tlbtol2tlb_req.txid  = t;
        l1tlbtol2tlb_req.laddr = a;
        acc_cyc = -1;
        for (int i = 0; i < 300 && acc_cyc < 0; i++) begin
            @(negedge clk);
            if (l1tlbtol2tlb_req_retry === 1'b0) begin
                acc_cyc = cyc;
                exp_q.push_back(model_ack(t, a));
            end
            @(posedge clk);
            #1;
        end
        l1tlbtol2tlb_req_valid = 1'b0;
        checks++;
        if (acc_cyc < 0) begin
            errors++;
            $display("FAIL req_accept: txid %0d not accepted, want accept within 300 cycles", t);
        end
    endtask

    task automatic wait_acks(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (got_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (l1tlbtol2tlb_req_retry !== 1'b1 || inv_retry !== 1'b1) begin
            errors++;
            $display("FAIL reset_retry: req_retry=%b inv_retry=%b, want 1 1", l1tlbtol2tlb_req_retry, inv_retry);
        end
        checks++;
        if (l2tlbtol1tlb_ack_valid !== 1'b0 || l2tlbtol1tlb_snoop_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: ack_valid=%b snoop_valid=%b, want 0 0", l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_snoop_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (l1tlbtol2tlb_req_retry !== 1'b0 || inv_retry !== 1'b0 || l1tlbtol2tlb_sack_retry !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_retry: req=%b inv=%b sack=%b, want 0 0 0", l1tlbtol2tlb_req_retry, inv_retry, l1tlbtol2tlb_sack_retry);
        end
        checks++;
        if (dut.err_sack !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_err_sack: got %b want 0", dut.err_sack);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int n;
        bit ok;
        clear_queues();
        send_req(5'd3, 39'h00_0054_3000, n);
        wait_acks(1, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_arrive: %0d acks, want 1", got_q.size());
        end else begin
            checks++;
            if (got_cyc[0] != n + WALK_LAT + 2) begin
                errors++;
                $display("FAIL single_latency: ack in cycle %0d, want %0d", got_cyc[0], n + WALK_LAT + 2);
            end
            checks++;
            if (got_q[0].txid !== 5'd3 || got_q[0].hpaddr !== 11'h543 ||
                got_q[0].ppaddr !== 3'd3 || got_q[0].fault !== 3'd0) begin
                errors++;
                $display("FAIL single_payload: txid=%0d hp=%h pp=%0d f=%0d, want 3 543 3 0",
                         got_q[0].txid, got_q[0].hpaddr, got_q[0].ppaddr, got_q[0].fault);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        clear_queues();
        for (int i = 0; i < 5; i++) send_req(TXID_W'($urandom), rand_laddr(), n);
        @(negedge clk);
        checks++;
        if (l1tlbtol2tlb_req_retry !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full_retry: req_retry=%b, want 1 with four queued", l1tlbtol2tlb_req_retry);
        end
        @(posedge clk);
        #1;
        wait_acks(5, 5 * (WALK_LAT + 4) + 20, ok);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL b2b_count: %0d acks, want 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_ack%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_ack_hold();
        int n;
        bit seen;
        bit ok;
        clear_queues();
        l2tlbtol1tlb_ack_retry = 1'b1;
        send_req(TXID_W'($urandom), rand_laddr(), n);
        send_req(TXID_W'($urandom), rand_laddr(), n);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (l2tlbtol1tlb_ack_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hold_ack_appear: ack_valid never rose, want 1");
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (l2tlbtol1tlb_ack_valid !== 1'b1 || l2tlbtol1tlb_ack !== exp_q[0]) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d valid=%b ack=%h, want 1 %h", i, l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack, exp_q[0]);
            end
        end
        @(posedge clk);
        #1;
        l2tlbtol1tlb_ack_retry = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL hold_release_count: %0d acks, want 1", got_q.size());
        end
        wait_acks(2, 40, ok);
        checks++;
        if (!ok || got_q.size() != 2) begin
            errors++;
            $display("FAIL hold_second_arrive: %0d acks, want 2", got_q.size());
        end else begin
            checks++;
            if (got_cyc[1] != got_cyc[0] + WALK_LAT + 2) begin
                errors++;
                $display("FAIL hold_no_walk: second ack cycle %0d, want %0d", got_cyc[1], got_cyc[0] + WALK_LAT + 2);
            end
            checks++;
            if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
                errors++;
                $display("FAIL hold_payload: got %h %h want %h %h", got_q[0], got_q[1], exp_q[0], exp_q[1]);
            end
        end
    endtask

    task automatic test_inv();
        int n;
        int icyc;
        logic [HPADDR_W-1:0] hp;
        clear_queues();
        checks++;
        if (dut.err_sack !== 1'b0) begin
            errors++;
            $display("FAIL inv_err_initial: err_sack=%b, want 0", dut.err_sack);
        end
        send_req(TXID_W'($urandom), rand_laddr(), n);
        repeat (3) @(posedge clk);
        #1;
        hp = HPADDR_W'($urandom);
        inv_valid   = 1'b1;
        inv.txid    = 5'd7;
        inv.hpaddr  = hp;
        icyc = -1;
        for (int i = 0; i < 100 && icyc < 0; i++) begin
            @(negedge clk);
            if (inv_retry === 1'b0) icyc = cyc;
            @(posedge clk);
            #1;
        end
        inv_valid = 1'b0;
        checks++;
        if (icyc < 0 || got_q.size() != 1) begin
            errors++;
            $display("FAIL inv_accept: inv cycle %0d acks %0d, want accept after 1 ack", icyc, got_q.size());
        end else begin
            checks++;
            if (icyc != got_cyc[0] + 1 || got_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL inv_after_ack: inv cycle %0d ack %h, want %0d %h", icyc, got_q[0], got_cyc[0] + 1, exp_q[0]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (snp_q.size() != 1) begin
            errors++;
            $display("FAIL snoop_count: %0d snoops, want 1", snp_q.size());
        end else begin
            checks++;
            if (snp_cyc[0] != icyc + 1 || snp_q[0].txid !== 5'd7 || snp_q[0].hpaddr !== hp) begin
                errors++;
                $display("FAIL snoop_payload: cycle %0d txid %0d hp %h, want %0d 7 %h", snp_cyc[0], snp_q[0].txid, snp_q[0].hpaddr, icyc + 1, hp);
            end
        end
        l1tlbtol2tlb_sack_valid = 1'b1;
        l1tlbtol2tlb_sack.txid  = 5'd5;
        @(posedge clk);
        #1;
        l1tlbtol2tlb_sack_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.err_sack !== 1'b1 || inv_retry !== 1'b1) begin
            errors++;
            $display("FAIL sack_wrong: err_sack=%b inv_retry=%b, want 1 1", dut.err_sack, inv_retry);
        end
        @(posedge clk);
        #1;
        l1tlbtol2tlb_sack_valid = 1'b1;
        l1tlbtol2tlb_sack.txid  = 5'd7;
        @(posedge clk);
        #1;
        l1tlbtol2tlb_sack_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inv_retry !== 1'b0 || dut.err_sack !== 1'b1) begin
            errors++;
            $display("FAIL sack_match: inv_retry=%b err_sack=%b, want 0 1", inv_retry, dut.err_sack);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n;
        clear_queues();
        for (int i = 0; i < 4; i++) send_req(TXID_W'($urandom), rand_laddr(), n);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (l2tlbtol1tlb_ack_valid !== 1'b0 || l2tlbtol1tlb_snoop_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid: ack=%b snoop=%b, want 0 0", l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_snoop_valid);
        end
        checks++;
        if (l1tlbtol2tlb_req_retry !== 1'b0 || inv_retry !== 1'b0 || dut.err_sack !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: req_retry=%b inv_retry=%b err_sack=%b, want 0 0 0",
                     l1tlbtol2tlb_req_retry, inv_retry, dut.err_sack);
        end
        repeat (4 * (WALK_LAT + 4)) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_flush: %0d acks after reset, want 0", got_q.size());
        end
    endtask

    task automatic test_fault();
        int n;
        bit ok;
        logic [LADDR_W-1:0]  la [3] = '{39'h01_0000_0000, 39'h01_0054_3000, 39'h00_007F_F000};
`ifdef L2TLB_FAULT_CHECK_EN
        logic [HPADDR_W-1:0] ehp [3] = '{11'h000, 11'h000, 11'h7FF};
        logic [PPADDR_W-1:0] epp [3] = '{3'd0, 3'd0, 3'd7};
        logic [FAULT_W-1:0]  efl [3] = '{3'd1, 3'd1, 3'd0};
`else
        logic [HPADDR_W-1:0] ehp [3] = '{11'h000, 11'h543, 11'h7FF};
        logic [PPADDR_W-1:0] epp [3] = '{3'd0, 3'd3, 3'd7};
        logic [FAULT_W-1:0]  efl [3] = '{3'd0, 3'd0, 3'd0};
`endif
        clear_queues();
        for (int i = 0; i < 3; i++) send_req(TXID_W'(i + 1), la[i], n);
        wait_acks(3, 3 * (WALK_LAT + 4) + 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fault_count: %0d acks, want 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i].txid !== TXID_W'(i + 1) || got_q[i].hpaddr !== ehp[i] ||
                    got_q[i].ppaddr !== epp[i] || got_q[i].fault !== efl[i]) begin
                    errors++;
                    $display("FAIL fault_ack%0d: txid %0d hp %h pp %0d f %0d, want %0d %h %0d %0d", i,
                             got_q[i].txid, got_q[i].hpaddr, got_q[i].ppaddr, got_q[i].fault,
                             i + 1, ehp[i], epp[i], efl[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        localparam int NREQ = 16;
        int sent;
        bit acc;
        clear_queues();
        sent = 0;
        for (int c = 0; c < 3000 && (sent < NREQ || got_q.size() < NREQ); c++) begin
            l2tlbtol1tlb_ack_retry = ($urandom_range(0, 3) == 0);
            if (!l1tlbtol2tlb_req_valid && sent < NREQ && $urandom_range(0, 2) == 0) begin
                l1tlbtol2tlb_req_valid = 1'b1;
                l1tlbtol2tlb_req.txid  = TXID_W'($urandom);
                l1tlbtol2tlb_req.laddr = rand_laddr();
            end
            acc = 1'b0;
            @(negedge clk);
            if (l1tlbtol2tlb_req_valid && l1tlbtol2tlb_req_retry === 1'b0) begin
                exp_q.push_back(model_ack(l1tlbtol2tlb_req.txid, l1tlbtol2tlb_req.laddr));
                sent++;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) l1tlbtol2tlb_req_valid = 1'b0;
        end
        l2tlbtol1tlb_ack_retry = 1'b0;
        l1tlbtol2tlb_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sent != NREQ || got_q.size() != NREQ) begin
            errors++;
            $display("FAIL rand_count: sent %0d acks %0d, want %0d %0d", sent, got_q.size(), NREQ, NREQ);
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_ack%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ack_hold();
        test_inv();
        test_reset_mid();
        test_fault();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2tlb_resp.md
# l2tlb_resp

Responder end of the L1-TLB/L2-TLB protocol. Accepts translation requests from an L1 TLB (`ictlb` or `dctlb`), performs a fixed-latency identity "walk" and returns acks. It also injects invalidation snoops toward the L1 TLB and blocks until the matching snoop ack returns. It sits where the L2 TLB attaches and serves as the bring-up L2 TLB for L1 TLB and L1 verification.

## Interface
Parameters:
- `REQ_DEPTH`, 4: request FIFO entries (power of two, ≥2).
- `WALK_LAT`, 8: walk cycles per request (≥1).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `l1tlbtol2tlb_req_valid` in 1; `l1tlbtol2tlb_req_retry` out 1; `l1tlbtol2tlb_req` in `I_l1tlbtol2tlb_req_type`: translation request (uses `txid`, `laddr`).
- `l2tlbtol1tlb_ack_valid` out 1; `l2tlbtol1tlb_ack_retry` in 1; `l2tlbtol1tlb_ack` out `I_l2tlbtol1tlb_ack_type`: response (`txid`, `hpaddr`, `ppaddr`, `fault`).
- `inv_valid` in 1; `inv_retry` out 1; `inv` in `I_l2tlbtol1tlb_snoop_type`: invalidation command from the L2 side.
- `l2tlbtol1tlb_snoop_valid` out 1; `l2tlbtol1tlb_snoop_retry` in 1; `l2tlbtol1tlb_snoop` out `I_l2tlbtol1tlb_snoop_type`: snoop to the L1 TLB.
- `l1tlbtol2tlb_sack_valid` in 1; `l1tlbtol2tlb_sack_retry` out 1; `l1tlbtol2tlb_sack` in `I_l1tlbtol2tlb_sack_type`: snoop ack (`txid`).

## Operation
- Handshake on every port: a transfer occurs in a cycle where valid=1 and retry=0. The sender holds valid and payload stable while retry=1.
- Request FIFO: `req_retry` = FIFO full. A transfer pushes {txid, laddr}.
- FSM states: IDLE, WALK, ACK, SNOOP, WAIT_SACK.
- IDLE transitions:
  - If `inv_valid`=1, the FSM captures `inv` (`inv_retry`=0 this cycle only) and goes to SNOOP. Invalidation has priority over a non-empty FIFO.
  - Otherwise, if the FIFO is non-empty, the FSM pops the head, loads the counter with `WALK_LAT-1`, and goes to WALK.
  - `inv_retry`=1 in every state except IDLE.
- WALK: the counter decrements each cycle. At 0 the FSM builds the ack and goes to ACK.
- Ack contents:
  - txid = request txid.
  - hpaddr = laddr[22:12].
  - ppaddr = laddr[14:12].
  - fault = 3'b000.
- ACK: ack presented to the output flop. The FSM returns to IDLE in the cycle the flop accepts it.
- SNOOP: the captured snoop is presented to the output flop. On acceptance the FSM goes to WAIT_SACK.
- WAIT_SACK: `sack_retry`=0 in all states.
  - A sack whose txid equals the snoop txid returns the FSM to IDLE.
  - A sack with any other txid, or any sack outside WAIT_SACK, is consumed and dropped. It raises the sticky `err_sack` internal flag (bench-visible through hierarchy).
- One request is in flight at a time. Acks return in request order.

## Timing
- Reset values: all `*_valid` outputs 0; `req_retry`=1 and `inv_retry`=1 during reset, then `req_retry`=0 and `inv_retry`=0 in the first cycle after reset.
- Request accepted in cycle N with the FIFO empty, IDLE, and no backpressure: `ack_valid`=1 in cycle N+`WALK_LAT`+2.
- Snoop latency: inv accepted in cycle N → `snoop_valid` in cycle N+1.
- Output flops: one entry each, fflop semantics. While `ack_retry`=1 the ack is held and the FSM stays in ACK.
- FIFO full boundary: a push and a pop in the same cycle while full is not possible, because `req_retry` is derived from the registered count. A pop frees a slot the next cycle.
- Wrap-around: read and write pointers are log2(`REQ_DEPTH`) bits and wrap naturally. Count is log2(`REQ_DEPTH`)+1 bits.
- `inv` arriving during WALK or ACK waits, with `inv_retry`=1, until IDLE.
- Reset mid-operation: the FIFO empties, the counter clears, any pending ack or snoop is dropped, the FSM goes to IDLE, and `err_sack` clears.

## Configuration
- `L2TLB_FAULT_CHECK_EN` defined: a request whose laddr has any bit above bit 22 set gets an ack with fault=3'b001 and hpaddr=ppaddr=0. Walk latency is unchanged.
- Not defined: fault is always 3'b000 and upper laddr bits are ignored.

## Structure
- Shared package (`scmem.vh`): the `I_*` request, ack, snoop and sack typedefs, and the fault encodings FAULT_NONE=3'b000 and FAULT_RANGE=3'b001.
- FSM state enum and FIFO entry struct: local to the block.
- Sub-module `l2tlb_req_fifo` (parameterized depth, valid/retry push and pop).
- Outputs: existing `fflop` instances for the ack and snoop ports.

## Test plan
- Single request txid=3, laddr=0x0054_3000, `WALK_LAT`=8, no backpressure → ack at N+10 with txid=3, hpaddr=0x543, ppaddr=3, fault=0.
- Five back-to-back requests with `REQ_DEPTH`=4 and the FSM busy → `req_retry`=1 once four are queued; all five acks arrive in order with no loss or duplicate.
- Ack held with `ack_retry`=1 for 20 cycles → ack payload stable, no new WALK starts, release delivers exactly one ack.
- inv txid=7 arrives during WALK → snoop issued only after the ack; a sack with txid=5 sets `err_sack` and keeps WAIT_SACK; a sack with txid=7 returns to IDLE.
- Reset asserted mid-WALK with 3 queued requests → all valids 0 next cycle, no ack for the flushed requests afterward.
- With `L2TLB_FAULT_CHECK_EN`, laddr=0x1_0000_0000 → fault=3'b001, hpaddr=0; without it → fault=0, hpaddr=0.
